rect_fill: RTL and testbench
============================

RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter WIDTH, 640, visible columns per frame.
REQ-002 Parameter HEIGHT, 480, visible rows per frame.
REQ-003 Parameter COLOR_W, 12, pixel width (4:4:4 RGB).
REQ-004 Parameter ADDR_W, 19, frame-buffer write-address width.
REQ-005 Port clk  in  1  single clock; all logic rising-edge.
REQ-006 Port rstn  in  1  reset, asynchronous, active-low.
REQ-007 Port cmd_valid  in  1  command offered.
REQ-008 Port cmd_ready  out  1  block accepts command this cycle.
REQ-009 Port cmd_x0 / cmd_x1  in  10 each  inclusive column bounds.
REQ-010 Port cmd_y0 / cmd_y1  in  9 each  inclusive row bounds.
REQ-011 Port cmd_color  in  COLOR_W  fill colour.
REQ-012 Port stall  in  1  frame-buffer write port cannot accept; hold.
REQ-013 Port we  out  1  frame-buffer write strobe.
REQ-014 Port addr  out  ADDR_W  write address, row*WIDTH+col.
REQ-015 Port dout  out  COLOR_W  write data.
REQ-016 Port busy  out  1  command in progress.
REQ-017 Port done  out  1  one-cycle pulse, command finished.
REQ-018 Port err  out  1  one-cycle pulse with done, command rejected.

Function
REQ-019 FSM states IDLE, CHECK, FILL, FIN; cmd_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: command captured when cmd_valid&&cmd_ready (cycle N); IDLE->CHECK.
REQ-021 CHECK (N+1): clamp x1 to WIDTH-1, y1 to HEIGHT-1; x0>=WIDTH, y0>=HEIGHT, x0>x1 or y0>y1 after clamp -> reject, CHECK->FIN with err; else CHECK->FILL with addr=y0*WIDTH+x0.
REQ-022 FILL: first we at N+2; one pixel per non-stalled cycle, raster order, left-to-right then top-to-bottom; dout=captured colour.
REQ-023 addr SHALL advance by +1 within a row and by WIDTH-(x1-x0) at row end; no multiplier in FILL path.
REQ-024 stall=1 in FILL: we=0, addr/dout/counters hold; resume on same pixel when stall=0.
REQ-025 After last pixel (x=x1,y=y1) written: FILL->FIN; FIN asserts done one cycle, ->IDLE.
REQ-026 Accepted rectangle SHALL produce exactly (x1-x0+1)*(y1-y0+1) writes, no duplicates, no out-of-frame address.
REQ-027 busy=1 in CHECK, FILL, FIN; cmd_valid ignored while busy.
REQ-028 Maximum address WIDTH*HEIGHT-1 (307199); no wrap past it.
REQ-029 stall ignored outside FILL.

Reset
REQ-030 rstn=0 SHALL asynchronously force IDLE, cmd_ready=0 while asserted, we=0, addr=0, dout=0, busy=0, done=0, err=0.
REQ-031 Reset mid-command drops it; no further writes; cmd_ready=1 first cycle after release.

Structure
REQ-032 Shared package vga_pkg holds WIDTH, HEIGHT, COLOR_W, ADDR_W defaults and FSM state encoding.
REQ-033 One sub-module natural: rect_clip (combinational clamp/reject of captured bounds); rest single FSM plus x/y counters.

Verification
REQ-034 (1,1)-(2,2) colour 0x0F0 accepted cycle N -> we at N+2..N+5, addr 641,642,1281,1282, dout 0x0F0, done at N+6, err=0.
REQ-035 (0,0)-(639,479) colour 0x000 -> 307200 writes, addr 0..307199 contiguous, done one cycle after last.
REQ-036 (630,470)-(700,500) -> clamped to (639,479), 100 writes, first 301430, last 307199.
REQ-037 x0=5,x1=4 -> zero writes, done and err pulse at N+2, cmd_ready=1 at N+3.
REQ-038 (0,0)-(3,0) with stall=1 on N+3..N+5 -> writes addr 0 at N+2, 1 at N+6, 2 at N+7, 3 at N+8, done N+9.
REQ-039 rstn=0 during FILL of (0,0)-(9,9) -> we=0 immediately, all outputs reset values, next command processed normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the frame-buffer drawing blocks: default frame
// geometry, pixel/address widths and the rectangle-fill FSM encoding.
package vga_pkg;

  localparam int DEF_WIDTH   = 640;
  localparam int DEF_HEIGHT  = 480;
  localparam int DEF_COLOR_W = 12;
  localparam int DEF_ADDR_W  = 19;

  // Command coordinate widths are fixed by the command interface.
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FILL  = 2'd2,
    ST_FIN   = 2'd3
  } fill_state_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clamp/reject of a captured rectangle: the far corner is
// clamped to the last visible column/row, and a rectangle whose near corner
// lies outside the frame or past the clamped far corner is rejected.
module rect_clip
  import vga_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x1_clamp,
  output logic [Y_W-1:0] y1_clamp,
  output logic           reject
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  // Clamp the far corner, then test the near corner against frame and clamp.
  always_comb begin
    x1_clamp = (x1 > X_MAX) ? X_MAX : x1;
    y1_clamp = (y1 > Y_MAX) ? Y_MAX : y1;
    reject   = (x0 > X_MAX) || (y0 > Y_MAX) ||
               (x0 > x1_clamp) || (y0 > y1_clamp);
  end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: accepts one rectangle command at a time, clips it to
// the visible frame and writes the fill colour into the frame buffer one
// pixel per non-stalled cycle in raster order. The write address is stepped
// incrementally during the fill; the only multiply is the start address,
// formed once while the command is checked.
module rect_fill
  import vga_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               stall,
  output logic               we,
  output logic [ADDR_W-1:0]  addr,
  output logic [COLOR_W-1:0] dout,
  output logic               busy,
  output logic               done,
  output logic               err
);

  fill_state_t state, state_nxt;

  // Raw command as captured at the handshake.
  logic [X_W-1:0] cap_x0, cap_x1;
  logic [Y_W-1:0] cap_y0, cap_y1;

  // Clipped bounds and walking counters used during the fill.
  logic [X_W-1:0] x_lo, x_hi, x_cnt;
  logic [Y_W-1:0] y_hi, y_cnt;
  logic           rej_q;

  logic [X_W-1:0] x1_clamp;
  logic [Y_W-1:0] y1_clamp;
  logic           reject;

  logic accept;
  logic advance;
  logic row_end;
  logic last_px;

  rect_clip #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_clip (
    .x0       (cap_x0),
    .x1       (cap_x1),
    .y0       (cap_y0),
    .y1       (cap_y1),
    .x1_clamp (x1_clamp),
    .y1_clamp (y1_clamp),
    .reject   (reject)
  );

  assign accept  = cmd_valid && cmd_ready;
  assign advance = (state == ST_FILL) && !stall;
  assign row_end = (x_cnt == x_hi);
  assign last_px = row_end && (y_cnt == y_hi);

  // State register; reset drops any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: capture, check, fill until the last pixel, one-cycle finish.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = reject ? ST_FIN : ST_FILL;
      ST_FILL:  if (advance && last_px) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; a stall only suppresses the write strobe.
  always_comb begin
    cmd_ready = rstn && (state == ST_IDLE);
    we        = advance;
    busy      = (state != ST_IDLE);
    done      = (state == ST_FIN);
    err       = (state == ST_FIN) && rej_q;
  end

  // Command capture, start address and raster walk of the write address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_x0 <= '0;
      cap_x1 <= '0;
      cap_y0 <= '0;
      cap_y1 <= '0;
      x_lo   <= '0;
      x_hi   <= '0;
      y_hi   <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
      rej_q  <= 1'b0;
      addr   <= '0;
      dout   <= '0;
    end else begin
      if (accept) begin
        cap_x0 <= cmd_x0;
        cap_x1 <= cmd_x1;
        cap_y0 <= cmd_y0;
        cap_y1 <= cmd_y1;
        dout   <= cmd_color;
      end
      if (state == ST_CHECK) begin
        x_lo  <= cap_x0;
        x_hi  <= x1_clamp;
        y_hi  <= y1_clamp;
        x_cnt <= cap_x0;
        y_cnt <= cap_y0;
        rej_q <= reject;
        // A rejected command may lie outside the frame, so keep the old address.
        if (!reject)
          addr <= ADDR_W'(cap_y0) * ADDR_W'(WIDTH) + ADDR_W'(cap_x0);
      end
      if (advance && !last_px) begin
        if (row_end) begin
          x_cnt <= x_lo;
          y_cnt <= y_cnt + Y_W'(1);
          addr  <= addr + ADDR_W'(WIDTH) - ADDR_W'(x_hi - x_lo);
        end else begin
          x_cnt <= x_cnt + X_W'(1);
          addr  <= addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: each command pushes its expected pixel
// writes (address, colour, cycle) into a scoreboard that a negedge monitor
// drains as the DUT writes; done/err timing is checked against the model.
module tb_rect_fill;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x0, cmd_x1;
  logic [8:0]  cmd_y0, cmd_y1;
  logic [11:0] cmd_color;
  logic        stall;
  logic        we;
  logic [18:0] addr;
  logic [11:0] dout;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    int a;
    int c;
    int cy;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_err;
  int   cyc;
  int   cmd_n;
  int   exp_done_cyc;
  bit   exp_err;
  bit   exp_pending;

  rect_fill dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_x1    (cmd_x1),
    .cmd_y0    (cmd_y0),
    .cmd_y1    (cmd_y1),
    .cmd_color (cmd_color),
    .stall     (stall),
    .we        (we),
    .addr      (addr),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every write and every done pulse is checked.
  always @(negedge clk) begin
    if (rstn) begin
      if (we) begin
        if (sb.size() == 0) begin
          chk("unexpected_we", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("addr", addr, e.a);
          chk("dout", dout, e.c);
          if (e.cy >= 0) chk("write_cycle", cyc, e.cy);
        end
      end
      if (done) begin
        if (!exp_pending) begin
          chk("unexpected_done", 1, 0);
        end else begin
          if (exp_done_cyc >= 0) chk("done_cycle", cyc, exp_done_cyc);
          chk("err", err, exp_err);
          chk("writes_left", sb.size(), 0);
        end
      end else if (err) begin
        chk("err_without_done", err, 0);
      end
    end
  end

  // Offer a command, build its expected writes, optionally stall the fill
  // for slen cycles starting at cycle N+soff.
  task automatic launch(input int x0, input int x1, input int y0, input int y1,
                        input int color, input int soff, input int slen,
                        input bit rnd, input bit hold);
    int xe, ye, n, t, c;
    bit rj;
    @(negedge clk);
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_x0    = 10'(x0);
    cmd_x1    = 10'(x1);
    cmd_y0    = 9'(y0);
    cmd_y1    = 9'(y1);
    cmd_color = 12'(color);
    cmd_valid = 1'b1;
    cmd_n     = cyc;
    xe = (x1 > W - 1) ? W - 1 : x1;
    ye = (y1 > H - 1) ? H - 1 : y1;
    rj = (x0 > W - 1) || (y0 > H - 1) || (x0 > xe) || (y0 > ye);
    n  = 0;
    if (!rj) begin
      for (int y = y0; y <= ye; y++) begin
        for (int x = x0; x <= xe; x++) begin
          c = rnd ? -1 : cmd_n + 2 + n;
          if (!rnd && soff > 0 && c >= cmd_n + soff) c += slen;
          sb.push_back('{y * W + x, color, c});
          n++;
        end
      end
    end
    exp_err      = rj;
    exp_done_cyc = rnd ? -1 : (rj ? cmd_n + 2 : cmd_n + 2 + n + ((soff > 0) ? slen : 0));
    exp_pending  = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", cmd_ready, 0);
    if (hold) begin
      cmd_x0 = 10'd0;
      cmd_x1 = 10'd5;
      cmd_y0 = 9'd0;
      cmd_y1 = 9'd5;
      cmd_color = 12'hFFF;
    end else begin
      cmd_valid = 1'b0;
    end
    if (soff > 0) begin
      repeat (soff - 1) @(posedge clk);
      #1 stall = 1'b1;
      repeat (slen) @(posedge clk);
      #1 stall = 1'b0;
    end
  endtask

  // Wait (bounded) for the done pulse; returns one cycle after it.
  task automatic wait_done(input bit rnd);
    int t;
    bit seen;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 5000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (rnd) #1 stall = 1'($urandom_range(0, 1));
      t++;
    end
    if (!seen) chk("done_timeout", 0, 1);
    stall     = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_pending = 1'b0;
    if (!seen) sb.delete();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    exp_pending = 1'b0;
    exp_err = 1'b0;
    exp_done_cyc = -1;
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_x0 = '0;
    cmd_x1 = '0;
    cmd_y0 = '0;
    cmd_y1 = '0;
    cmd_color = '0;
    stall = 1'b0;

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    // 2x2 square; cmd_valid kept high with other data while busy.
    launch(1, 2, 1, 2, 12'h0F0, 0, 0, 1'b0, 1'b1);
    wait_done(1'b0);

    // Clamped bottom-right corner: 10x10 pixels ending at the last address.
    launch(630, 700, 470, 500, 12'hABC, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);

    // Reject x0>x1 with stall held high (stall has no effect outside fill).
    stall = 1'b1;
    launch(5, 4, 0, 0, 12'h123, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);
    chk("ready_after_reject", cmd_ready, 1);
    chk("ready_cycle", cyc, cmd_n + 3);

    // Rejects for near corner outside the frame.
    launch(0, 3, 480, 500, 12'h321, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);
    launch(640, 700, 0, 3, 12'h321, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);

    // Single row with stall on N+3..N+5.
    launch(0, 3, 0, 0, 12'h00F, 3, 3, 1'b0, 1'b0);
    wait_done(1'b0);

    // Full last row, through the maximum address.
    launch(0, 639, 479, 479, 12'h5A5, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);

    // Random stalls across a multi-row rectangle.
    launch(10, 17, 20, 25, 12'h7E1, 0, 0, 1'b1, 1'b0);
    wait_done(1'b1);

    // Reset in the middle of a fill.
    launch(0, 9, 0, 9, 12'hF00, 0, 0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_addr", addr, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 0);
    sb.delete();
    exp_pending = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_hold_we", we, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", cmd_ready, 1);
    chk("busy_after_midrst", busy, 0);

    // Normal operation after the aborted command.
    launch(3, 4, 4, 5, 12'h0A0, 0, 0, 1'b0, 1'b0);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    chk("final_scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
